// File: rtl/queen_stack_pkg.sv
// Shared types and defaults for the queen_stack LIFO responder.
// Optional random-read port is enabled with the STACK_RANDOM_READ_EN macro.
package queen_stack_pkg;

  localparam int DEFAULT_DATA_WIDTH = 3;
  localparam int DEFAULT_DEPTH      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } op_t;

endpackage

// File: rtl/queen_stack_if.sv
// Request/response bundle between the queen controller (master) and queen_stack (slave).
// STACK_RANDOM_READ_EN adds the rd_index/rd_data lookup pair.
interface queen_stack_if
  import queen_stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) ();

  localparam int CW = $clog2(DEPTH + 1);

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  stack_ready;
  logic                  underflow;
  logic                  overflow;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;

`ifdef STACK_RANDOM_READ_EN
  logic [$clog2(DEPTH)-1:0] rd_index;
  logic [DATA_WIDTH-1:0]    rd_data;

  modport master (
    output push, pop, din, rd_index,
    input  dout, stack_ready, underflow, overflow, empty, full, count, rd_data
  );

  modport slave (
    input  push, pop, din, rd_index,
    output dout, stack_ready, underflow, overflow, empty, full, count, rd_data
  );
`else
  modport master (
    output push, pop, din,
    input  dout, stack_ready, underflow, overflow, empty, full, count
  );

  modport slave (
    input  push, pop, din,
    output dout, stack_ready, underflow, overflow, empty, full, count
  );
`endif

endinterface

// File: rtl/queen_stack_stack_mem.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, one combinational
// top-of-stack read port, plus a lookup read port when STACK_RANDOM_READ_EN is defined.
module stack_mem #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
`ifdef STACK_RANDOM_READ_EN
  input  logic [AW-1:0]         rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
`endif
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; entries above count are never read as valid,
  // and leaving it out lets the array map onto plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

`ifdef STACK_RANDOM_READ_EN
  // Bottom entry is index 0; indices at or above count return stale contents.
  assign rd_data = mem[rd_index];
`endif

endmodule

// File: rtl/queen_stack.sv
// Handshaked LIFO for the 8-queen controller: IDLE -> EXEC -> ACK per request.
// Define STACK_RANDOM_READ_EN to expose the combinational rd_index/rd_data lookup.
module queen_stack
  import queen_stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input logic          clk,
  input logic          reset,
  queen_stack_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  state_t                state;
  state_t                state_next;
  op_t                   op_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] top_data;
  logic [CW-1:0]         count_q;
  logic                  underflow_q;
  logic                  overflow_q;

  logic                  latch_req;
  logic                  do_exec;
  logic                  stack_ready;
  logic                  mem_we;
  logic                  is_empty;
  logic                  is_full;
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign waddr    = count_q[AW-1:0];
  assign raddr    = AW'(count_q - CW'(1));
  assign mem_we   = do_exec && (op_q == OP_PUSH) && !is_full;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    latch_req   = 1'b0;
    do_exec     = 1'b0;
    stack_ready = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.push || bus.pop) begin
          latch_req  = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        do_exec    = 1'b1;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        stack_ready = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Push wins when both requests arrive together; a still-held pop is taken
  // on the next IDLE visit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_NONE;
      din_q       <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (latch_req) begin
        op_q <= bus.push ? OP_PUSH : OP_POP;
        if (bus.push) din_q <= bus.din;
      end
      if (do_exec) begin
        unique case (op_q)
          OP_PUSH: begin
            if (is_full) begin
              overflow_q <= 1'b1;
            end else begin
              count_q     <= count_q + CW'(1);
              underflow_q <= 1'b0;
            end
          end
          OP_POP: begin
            if (is_empty) begin
              underflow_q <= 1'b1;
            end else begin
              dout_q     <= top_data;
              count_q    <= count_q - CW'(1);
              overflow_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  stack_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk     (clk),
`ifdef STACK_RANDOM_READ_EN
    .rd_index(bus.rd_index),
    .rd_data (bus.rd_data),
`endif
    .we      (mem_we),
    .waddr   (waddr),
    .wdata   (din_q),
    .raddr   (raddr),
    .rdata   (top_data)
  );

  assign bus.dout        = dout_q;
  assign bus.stack_ready = stack_ready;
  assign bus.underflow   = underflow_q;
  assign bus.overflow    = overflow_q;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_queen_stack.sv
// Self-checking bench for queen_stack: queue-based LIFO model plus directed and random requests.
// Exercises rd_index/rd_data as well when STACK_RANDOM_READ_EN is defined.
module tb_queen_stack;
  import queen_stack_pkg::*;

  localparam int DW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  queen_stack_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  queen_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural model: the stack is a queue, flags and dout are plain variables.
  int stk[$];
  int m_dout;
  int m_uf;
  int m_of;
  int m_ready;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are compared against the model on every falling edge.
  always @(negedge clk) begin
    check("count",       bus.count,       stk.size());
    check("empty",       bus.empty,       (stk.size() == 0) ? 1 : 0);
    check("full",        bus.full,        (stk.size() == DEPTH) ? 1 : 0);
    check("dout",        bus.dout,        m_dout);
    check("underflow",   bus.underflow,   m_uf);
    check("overflow",    bus.overflow,    m_of);
    check("stack_ready", bus.stack_ready, m_ready);
  end

  task automatic model_reset();
    stk.delete();
    m_dout  = 0;
    m_uf    = 0;
    m_of    = 0;
    m_ready = 0;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One request, starting one time unit after a rising edge with the DUT in IDLE.
  // Inputs carry random junk during EXEC/ACK, which the DUT must ignore.
  task automatic op(input bit p, input bit q, input int d);
    bus.push = p;
    bus.pop  = q;
    bus.din  = DW'(d);
    @(posedge clk);
    #1;
    check("ready_in_exec", bus.stack_ready, 0);
    bus.push = 1'($urandom);
    bus.pop  = 1'($urandom);
    bus.din  = DW'($urandom);
    @(posedge clk);
    #1;
    if (p) begin
      if (stk.size() == DEPTH) m_of = 1;
      else begin
        stk.push_back(d & 7);
        m_uf = 0;
      end
    end else if (q) begin
      if (stk.size() == 0) m_uf = 1;
      else begin
        m_dout = stk.pop_back();
        m_of   = 0;
      end
    end
    m_ready = 1;
    check("ready_in_ack", bus.stack_ready, 1);
    @(posedge clk);
    #1;
    m_ready  = 0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
`ifdef STACK_RANDOM_READ_EN
    bus.rd_index = '0;
`endif
    apply_reset();
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_dout",  bus.dout,  0);

    // Three pushes, then three pops come back in reverse order.
    op(1, 0, 5);
    op(1, 0, 2);
    op(1, 0, 7);
    check("s1_count", bus.count, 3);
    op(0, 1, 0);
    check("s1_pop7", bus.dout, 7);
    op(0, 1, 0);
    check("s1_pop2", bus.dout, 2);
    op(0, 1, 0);
    check("s1_pop5", bus.dout, 5);
    check("s1_empty", bus.empty, 1);

    // Pop on empty after reset, then a push clears underflow.
    apply_reset();
    op(0, 1, 0);
    check("s2_underflow", bus.underflow, 1);
    check("s2_dout", bus.dout, 0);
    check("s2_count", bus.count, 0);
    op(1, 0, 4);
    check("s2_uf_clear", bus.underflow, 0);
    check("s2_count1", bus.count, 1);

    // Fill, overflow, then a pop clears overflow.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) op(1, 0, i);
    op(1, 0, 3);
    check("s3_overflow", bus.overflow, 1);
    check("s3_full", bus.full, 1);
    check("s3_count", bus.count, 8);
    op(0, 1, 0);
    check("s3_pop7", bus.dout, 7);
    check("s3_of_clear", bus.overflow, 0);

    // Simultaneous push/pop: push first, held pop on the next IDLE.
    apply_reset();
    op(1, 0, 1);
    op(1, 0, 2);
    op(1, 1, 6);
    check("s4_count3", bus.count, 3);
    op(0, 1, 0);
    check("s4_count2", bus.count, 2);
    check("s4_dout", bus.dout, 6);

    // Held pop drains three entries, fourth pulse signals underflow.
    apply_reset();
    op(1, 0, 1);
    op(1, 0, 2);
    op(1, 0, 3);
    op(0, 1, 0);
    check("s5_d3", bus.dout, 3);
    op(0, 1, 0);
    check("s5_d2", bus.dout, 2);
    op(0, 1, 0);
    check("s5_d1", bus.dout, 1);
    check("s5_uf_before", bus.underflow, 0);
    op(0, 1, 0);
    check("s5_underflow", bus.underflow, 1);
    check("s5_dout_held", bus.dout, 1);

    // Reset during EXEC of a push drops the request.
    apply_reset();
    bus.push = 1'b1;
    bus.din  = 3'd6;
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.push = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check("s6_count", bus.count, 0);
    check("s6_no_ready", bus.stack_ready, 0);
    op(1, 0, 5);
    op(1, 0, 2);
    check("s6_count2", bus.count, 2);
`ifdef STACK_RANDOM_READ_EN
    bus.rd_index = 3'd1;
    #1 check("s6_rd1", bus.rd_data, 2);
    bus.rd_index = 3'd0;
    #1 check("s6_rd0", bus.rd_data, 5);
`endif

    // Randomized traffic, biased so the stack visits both empty and full.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      bit p;
      bit q;
      r = int'($urandom_range(0, 9));
      p = (r < 5);
      q = (r >= 3);
      op(p, q, int'($urandom_range(0, 7)));
`ifdef STACK_RANDOM_READ_EN
      if (stk.size() > 0) begin
        int idx;
        idx = int'($urandom_range(0, stk.size() - 1));
        bus.rd_index = 3'(idx);
        #1 check("rand_rd", bus.rd_data, stk[idx]);
      end
`endif
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
